// File: rtl/melody_sequencer.sv
// Purpose : debounce a raw active-low button and, on each press, play an 8-note
//           melody from ROM as (half period, tone enable) for the buzzer stage.
// Latency : press to tone_en high is DEBOUNCE_CYCLES + 3 edges; outputs registered.
// Backpressure: none; the buzzer stage consumes the outputs every cycle.
// Ports   : clk, rst (sync, active high), btn_n (raw, async), loop_en;
//           tone_half_period[15:0], tone_en, busy, note_idx[2:0].
module melody_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned NOTE_TICKS      = 2700000,
  parameter int unsigned GAP_CYCLES      = 270000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_n,
  input  logic        loop_en,
  output logic [15:0] tone_half_period,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  note_idx
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES) - 32'd1;
  localparam logic [31:0] NT       = 32'(NOTE_TICKS);
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES) - 32'd1;
  localparam logic        HAS_GAP  = (GAP_CYCLES != 0);

  // Melody ROM: C5..C6 scale, half periods in 27 MHz cycles.
  function automatic logic [15:0] rom_hp(input logic [2:0] i);
    case (i)
      3'd0:    rom_hp = 16'd25800;
      3'd1:    rom_hp = 16'd22985;
      3'd2:    rom_hp = 16'd20478;
      3'd3:    rom_hp = 16'd19328;
      3'd4:    rom_hp = 16'd17220;
      3'd5:    rom_hp = 16'd15341;
      3'd6:    rom_hp = 16'd13667;
      default: rom_hp = 16'd12900;
    endcase
  endfunction

  function automatic logic [31:0] rom_dur(input logic [2:0] i);
    rom_dur = (i == 3'd7) ? 32'd2 : 32'd1;
  endfunction

  // Counter load value: the counter runs from dur*NOTE_TICKS-1 down to 0.
  function automatic logic [31:0] note_last(input logic [2:0] i);
    note_last = rom_dur(i) * NT - 32'd1;
  endfunction

  // ---------------- input path ----------------
  logic        sync1, sync2;
  logic        btn_db, btn_db_d;
  logic [31:0] db_cnt;
  logic        press;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      btn_db   <= 1'b1;
      btn_db_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      btn_db_d <= btn_db;
      if (sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  // One-cycle pulse on the debounced falling edge only; releases are ignored.
  assign press = btn_db_d & ~btn_db;

  // ---------------- sequencer FSM ----------------
  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [31:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      cnt              <= '0;
      tone_en          <= 1'b0;
      tone_half_period <= '0;
      busy             <= 1'b0;
      note_idx         <= '0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      cnt              <= cnt_n;
      // Outputs are registered from the next-state values so they change on
      // the same edge as the state itself.
      tone_en          <= (state_n == PLAY) && (rom_hp(idx_n) != 16'd0);
      tone_half_period <= (state_n == IDLE) ? 16'd0 : rom_hp(idx_n);
      busy             <= (state_n != IDLE);
      note_idx         <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = PLAY;
          idx_n   = 3'd0;
          cnt_n   = note_last(3'd0);
        end
      end
      PLAY: begin
        if (cnt != 32'd0) begin
          cnt_n = cnt - 32'd1;
        end else if (HAS_GAP) begin
          state_n = GAP;
          cnt_n   = GAP_LAST;
        end else if (idx != 3'd7) begin
          state_n = PLAY;
          idx_n   = 3'(idx + 3'd1);
          cnt_n   = note_last(3'(idx + 3'd1));
        end else if (loop_en) begin
          state_n = PLAY;
          idx_n   = 3'd0;
          cnt_n   = note_last(3'd0);
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt != 32'd0) begin
          cnt_n = cnt - 32'd1;
        end else if (idx != 3'd7) begin
          state_n = PLAY;
          idx_n   = 3'(idx + 3'd1);
          cnt_n   = note_last(3'(idx + 3'd1));
        end else if (loop_en) begin
          state_n = PLAY;
          idx_n   = 3'd0;
          cnt_n   = note_last(3'd0);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A press while playing aborts, overriding whatever else was decided.
    if (press && (state != IDLE)) begin
      state_n = IDLE;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;
  localparam int DB     = 4;
  localparam int NT     = 10;
  localparam int GP     = 2;
  localparam int PERIOD = 9 * NT + 8 * GP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_n = 1'b1;
  logic        loop_en = 1'b0;
  logic [15:0] tone_half_period;
  logic        tone_en;
  logic        busy;
  logic [2:0]  note_idx;

  melody_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .NOTE_TICKS(NT),
    .GAP_CYCLES(GP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .loop_en(loop_en),
    .tone_half_period(tone_half_period),
    .tone_en(tone_en),
    .busy(busy),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int HP[8]  = '{25800, 22985, 20478, 19328, 17220, 15341, 13667, 12900};
  int DUR[8] = '{1, 1, 1, 1, 1, 1, 1, 2};

  // Reference model: debounce rule plus "melody position = time since start".
  int cyc = 0;
  bit m_s1 = 1, m_s2 = 1, m_db = 1;
  int m_run = 0;
  bit m_press = 0;
  bit m_active = 0;
  int m_t0 = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0; m_press = 0; m_active = 0;
    end else begin
      if (m_press) begin
        if (m_active) m_active = 0;
        else begin m_active = 1; m_t0 = cyc; end
      end else if (m_active && !loop_en && (cyc - m_t0) >= PERIOD) begin
        m_active = 0;
      end
      m_press = 0;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db = m_s2;
          m_run = 0;
          m_press = (m_db == 0);
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  task automatic expect_now(output bit en, output bit bz, output int hp, output int idx);
    int pos;
    int len;
    en = 0; bz = 0; hp = 0; idx = -1;
    if (m_active) begin
      pos = (cyc - m_t0) % PERIOD;
      for (int n = 0; n < 8; n++) begin
        len = DUR[n] * NT;
        if (idx < 0) begin
          if (pos < len) begin
            en = 1; bz = 1; hp = HP[n]; idx = n;
          end else if (pos < len + GP) begin
            bz = 1; hp = HP[n]; idx = n;
          end else begin
            pos -= len + GP;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int busy_seen = 0;
  bit prev_en = 0;
  int rises[$];

  task automatic tick(input int n);
    bit e_en, e_bz;
    int e_hp, e_idx;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      expect_now(e_en, e_bz, e_hp, e_idx);
      chk("tone_en", 32'(tone_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_bz));
      chk("tone_half_period", 32'(tone_half_period), 32'(e_hp));
      if (e_idx >= 0) chk("note_idx", 32'(note_idx), 32'(e_idx));
      if (busy) busy_seen++;
      if (tone_en && !prev_en) rises.push_back(int'(tone_half_period));
      prev_en = tone_en;
    end
  endtask

  int n;
  bit saw_idle;

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    chk("reset_tone_en", 32'(tone_en), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hp", 32'(tone_half_period), 0);
    chk("reset_note_idx", 32'(note_idx), 0);

    // First press: latency and full non-loop melody
    busy_seen = 0;
    rises.delete();
    btn_n = 1'b0;
    n = 0;
    while (!tone_en && n < 20) begin tick(1); n++; end
    chk("press_latency", n, 7);
    chk("first_hp", 32'(tone_half_period), 25800);
    chk("first_idx", 32'(note_idx), 0);
    tick(10);
    btn_n = 1'b1;
    tick(120);
    chk("melody_busy_cycles", busy_seen, 106);
    chk("melody_note_count", rises.size(), 8);
    for (int i = 0; i < 8 && i < rises.size(); i++) chk("melody_note_hp", rises[i], HP[i]);

    // Glitches shorter than the debounce window
    busy_seen = 0;
    btn_n = 1'b0; tick(3); btn_n = 1'b1; tick(10);
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0; tick($urandom_range(1, 3));
      btn_n = 1'b1; tick($urandom_range(6, 12));
    end
    chk("glitch_no_activity", busy_seen, 0);
    btn_n = 1'b0; tick(6); btn_n = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("pulse6_starts", 32'(busy), 1);
    tick(130);

    // Abort during note 3, then hold without restart
    btn_n = 1'b0; tick(8); btn_n = 1'b1;
    n = 0;
    while (!(busy && note_idx == 3'd3) && n < 200) begin tick(1); n++; end
    chk("reach_note3", 32'(note_idx), 3);
    btn_n = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(1); n++; end
    chk("abort_latency", n, 7);
    chk("abort_tone_en", 32'(tone_en), 0);
    busy_seen = 0;
    tick(40);
    chk("hold_no_restart", busy_seen, 0);
    btn_n = 1'b1;
    tick(10);

    // Loop mode wraps from note 7 to note 0 without idling
    loop_en = 1'b1;
    btn_n = 1'b0; tick(8); btn_n = 1'b1;
    n = 0;
    while (!(busy && note_idx == 3'd7 && !tone_en) && n < 200) begin tick(1); n++; end
    chk("reach_note7_gap", 32'(busy && note_idx == 3'd7 && !tone_en), 1);
    n = 0;
    saw_idle = 0;
    while (!(tone_en && note_idx == 3'd0) && n < 10) begin
      tick(1); n++;
      if (!busy) saw_idle = 1;
    end
    chk("loop_wrap_note0", 32'(tone_en && note_idx == 3'd0), 1);
    chk("loop_no_idle", 32'(saw_idle), 0);
    tick($urandom_range(0, 150));
    btn_n = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(1); n++; end
    chk("loop_abort", 32'(busy), 0);
    btn_n = 1'b1;
    tick(10);
    loop_en = 1'b0;

    // Reset in the middle of note 5
    btn_n = 1'b0; tick(8); btn_n = 1'b1;
    n = 0;
    while (!(tone_en && note_idx == 3'd5) && n < 200) begin tick(1); n++; end
    chk("reach_note5", 32'(tone_en && note_idx == 3'd5), 1);
    tick($urandom_range(0, 5));
    rst = 1'b1;
    tick(1);
    chk("midrst_tone_en", 32'(tone_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_hp", 32'(tone_half_period), 0);
    chk("midrst_idx", 32'(note_idx), 0);
    rst = 1'b0;
    tick(5);
    btn_n = 1'b0;
    n = 0;
    while (!tone_en && n < 20) begin tick(1); n++; end
    chk("post_rst_latency", n, 7);
    chk("post_rst_idx", 32'(note_idx), 0);
    tick(5);
    btn_n = 1'b1;
    tick(120);

    // Random button activity against the model
    for (int i = 0; i < 40; i++) begin
      btn_n = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 12));
    end
    btn_n = 1'b1;
    tick(150);
    chk("final_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Upstream control stage for the KY-006 buzzer tone generator. It debounces the raw active-low button and, on each press, plays a fixed 8-note melody from an internal ROM. For each note it presents a half-period value in clock cycles and a tone-enable to the buzzer stage; the buzzer stage only toggles its pin. A second press aborts playback, and an optional loop mode repeats the melody.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable synchronized samples needed to accept a new button level (10 ms at 27 MHz); must be ≥ 1.
- `NOTE_TICKS`, default 2700000: clock cycles per duration unit (100 ms at 27 MHz); must be ≥ 1.
- `GAP_CYCLES`, default 270000: silent cycles after every note; 0 means no gap.
- `clk`, input, 1: system clock, 27 MHz. One clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_n`, input, 1: raw button, active low, asynchronous to `clk`.
- `loop_en`, input, 1: 1 means restart at note 0 after the last note; sampled at end of the last note's gap.
- `tone_half_period`, output, 16: buzzer toggle interval in clk cycles; 0 means rest.
- `tone_en`, output, 1: 1 means the buzzer stage must oscillate; 0 means it must hold its counter and pin low.
- `busy`, output, 1: high in PLAY or GAP.
- `note_idx`, output, 3: index of the current ROM entry.

## Operation
- Input path: `btn_n` passes through a 2-FF synchronizer (reset value 1), then a debounce counter.
  - `btn_db` (reset 1) takes the synchronized level after `DEBOUNCE_CYCLES` consecutive cycles that differ from it.
  - Any mismatch-free cycle (input equal to `btn_db`) clears the counter.
- Press event: a one-cycle pulse when `btn_db` goes 1→0. Release edges are ignored.
- ROM (half period, duration units), indices 0–7:
  - 0: 25800, 1
  - 1: 22985, 1
  - 2: 20478, 1
  - 3: 19328, 1
  - 4: 17220, 1
  - 5: 15341, 1
  - 6: 13667, 1
  - 7: 12900, 2
  - This is a C5–C6 scale at 27 MHz.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: on press, go to PLAY with idx = 0 and the duration counter loaded.
  - PLAY: `tone_en` = 1 when the ROM half period ≠ 0. Hold for exactly dur × `NOTE_TICKS` cycles, then go to GAP. If `GAP_CYCLES` = 0, go straight to the next note.
  - GAP: `tone_en` = 0 and `tone_half_period` holds its value for `GAP_CYCLES` cycles. Then:
    - idx < 7: idx + 1, go to PLAY.
    - idx = 7 and `loop_en` = 1: idx = 0, go to PLAY.
    - otherwise: go to IDLE.
  - A press in PLAY or GAP aborts to IDLE on the next edge. Abort wins over any same-cycle transition.
- Duration and gap counters are 32 bits. dur × `NOTE_TICKS` must fit in 32 bits.
- All outputs are registered.
- Buzzer contract: the buzzer stage toggles its pin every `tone_half_period` + 1 cycles while `tone_en` = 1, and resets its counter when `tone_en` = 0 or the half period changes.

## Timing
- Reset values: state IDLE, `tone_en` 0, `tone_half_period` 0, `busy` 0, `note_idx` 0, debounce counter 0.
- Reset mid-playback: outputs take their reset values on the edge where `rst` is sampled high.
- Press latency: when `btn_n` falls and stays low, `tone_en` and `busy` go high exactly `DEBOUNCE_CYCLES` + 3 rising edges later. This is 2 synchronizer edges, `DEBOUNCE_CYCLES` debounce edges, and 1 FSM edge.
- `tone_half_period` and `note_idx` update on the same edge that `tone_en` rises.
- Note n: `tone_en` stays high for exactly dur(n) × `NOTE_TICKS` cycles, then low for exactly `GAP_CYCLES` cycles.
- Non-loop melody total, first rise of `tone_en` to `busy` falling: 9 × `NOTE_TICKS` + 8 × `GAP_CYCLES` cycles.
- Glitches: a low pulse on `btn_n` that lasts fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- Holding the button down produces exactly one event. A new press requires a debounced release first.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES` = 4, `NOTE_TICKS` = 10, `GAP_CYCLES` = 2.
- Reset, then idle 20 cycles. Required: all outputs 0. Then `btn_n` low: `tone_en` rises on edge 7, `tone_half_period` = 25800, `note_idx` = 0.
- Full melody with `loop_en` = 0. Required: 8 notes with the exact half periods above. Note widths are 10 cycles ×7, then 20. Each gap is 2 cycles. `busy` is high for 106 cycles, then IDLE.
- `btn_n` low pulse of 3 cycles. Required: no activity. A low pulse of 6 cycles: playback starts.
- Second debounced press during note 3. Required: IDLE on the next edge after the event, `tone_en` = 0, `busy` = 0. Holding the button does not restart playback.
- `loop_en` = 1. Required: after note 7's gap, `note_idx` = 0 and `tone_en` = 1 with no IDLE cycle in between.
- `rst` pulsed for 1 cycle in the middle of note 5. Required: all outputs 0 on that edge. A press after reset starts again from note 0.
